// File: rtl/traffic_phase_controller.sv
// Intersection phase sequencer: divides the system clock down to a 1 Hz tick,
// runs the per-phase countdown, drives both light groups and a flashing-yellow mode.

package traffic_phase_pkg;

  typedef enum logic [2:0] {
    ROW_GREEN  = 3'd0,
    ROW_YELLOW = 3'd1,
    CLEAR_A    = 3'd2,
    COL_GREEN  = 3'd3,
    COL_YELLOW = 3'd4,
    CLEAR_B    = 3'd5,
    FLASH      = 3'd6
  } phase_e;

  // Light encodings are {red, yellow, green}.
  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_OFF    = 3'b000;

endpackage

module traffic_phase_controller
  import traffic_phase_pkg::*;
#(
  parameter int DIVIDER      = 100000000,
  parameter int GREEN_TIME   = 30,
  parameter int YELLOW_TIME  = 3,
  parameter int ALL_RED_TIME = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       col_request,
  input  logic       flash,
  output logic [2:0] row_lights,
  output logic [2:0] column_lights,
  output logic [6:0] remaining,
  output logic [2:0] phase,
  output logic       tick
);

  localparam int              DIV_W    = $clog2(DIVIDER);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVIDER - 1);
  localparam logic [6:0]      GREEN_T  = 7'(GREEN_TIME);
  localparam logic [6:0]      YELLOW_T = 7'(YELLOW_TIME);
  localparam logic [6:0]      ALLRED_T = 7'(ALL_RED_TIME);

  logic [DIV_W-1:0] div_count;
  logic             tick_now;
  phase_e           state;
  phase_e           state_next;
  logic [6:0]       remaining_next;
  logic             flash_on;
  logic             flash_on_next;
  logic             col_pending;

  // Returns {row, column} lights for a phase; flash_on only matters in FLASH.
  function automatic logic [5:0] lights_for(input phase_e p, input logic on);
    case (p)
      ROW_GREEN:  return {LIGHT_GREEN, LIGHT_RED};
      ROW_YELLOW: return {LIGHT_YELLOW, LIGHT_RED};
      COL_GREEN:  return {LIGHT_RED, LIGHT_GREEN};
      COL_YELLOW: return {LIGHT_RED, LIGHT_YELLOW};
      FLASH:      return on ? {LIGHT_YELLOW, LIGHT_YELLOW} : {LIGHT_OFF, LIGHT_OFF};
      default:    return {LIGHT_RED, LIGHT_RED};
    endcase
  endfunction

  // Phase updates happen on the same edge that raises tick, so the new phase
  // and the tick pulse become visible together.
  assign tick_now = (div_count == DIV_LAST);

  // NOTE: sequential state is always written with non-blocking assignments so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_count <= '0;
      tick      <= 1'b0;
    end else begin
      div_count <= tick_now ? '0 : div_count + 1'b1;
      tick      <= tick_now;
    end
  end

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    flash_on_next  = flash_on;
    if (flash) begin
      state_next     = FLASH;
      remaining_next = 7'd0;
      flash_on_next  = (state == FLASH) ? !flash_on : 1'b1;
    end else if (state == FLASH) begin
      state_next     = CLEAR_B;
      remaining_next = ALLRED_T;
      flash_on_next  = 1'b0;
    end else if (remaining > 7'd1) begin
      remaining_next = remaining - 7'd1;
    end else if (state == ROW_GREEN && !col_pending) begin
      // No column demand: hold the row on green for another full period.
      remaining_next = GREEN_T;
    end else begin
      case (state)
        ROW_GREEN: begin
          state_next     = ROW_YELLOW;
          remaining_next = YELLOW_T;
        end
        ROW_YELLOW: begin
          state_next     = CLEAR_A;
          remaining_next = ALLRED_T;
        end
        CLEAR_A: begin
          state_next     = COL_GREEN;
          remaining_next = GREEN_T;
        end
        COL_GREEN: begin
          state_next     = COL_YELLOW;
          remaining_next = YELLOW_T;
        end
        COL_YELLOW: begin
          state_next     = CLEAR_B;
          remaining_next = ALLRED_T;
        end
        CLEAR_B: begin
          state_next     = ROW_GREEN;
          remaining_next = GREEN_T;
        end
        default: begin
          state_next     = CLEAR_B;
          remaining_next = ALLRED_T;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                       <= CLEAR_B;
      remaining                   <= ALLRED_T;
      flash_on                    <= 1'b0;
      {row_lights, column_lights} <= {LIGHT_RED, LIGHT_RED};
    end else if (tick_now) begin
      state                       <= state_next;
      remaining                   <= remaining_next;
      flash_on                    <= flash_on_next;
      {row_lights, column_lights} <= lights_for(state_next, flash_on_next);
    end
  end

  // Entering column green consumes the demand; that clear beats a same-cycle set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_pending <= 1'b0;
    end else if (tick_now && state != COL_GREEN && state_next == COL_GREEN) begin
      col_pending <= 1'b0;
    end else if (col_request && state != COL_GREEN) begin
      col_pending <= 1'b1;
    end
  end

  assign phase = 3'(state);

  no_conflicting_greens: assert property (
    @(posedge clock) disable iff (!reset) !(row_lights[0] && column_lights[0]));

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Scoreboard bench: expected per-tick phase/remaining/lights are queued as
// stimulus is applied and popped as each tick pulse appears.

module tb_traffic_phase_controller;

  localparam int DIV = 4;
  localparam int GT  = 5;
  localparam int YT  = 2;
  localparam int AR  = 1;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       col_request = 1'b0;
  logic       flash = 1'b0;
  logic [2:0] row_lights;
  logic [2:0] column_lights;
  logic [6:0] remaining;
  logic [2:0] phase;
  logic       tick;

  traffic_phase_controller #(
    .DIVIDER(DIV), .GREEN_TIME(GT), .YELLOW_TIME(YT), .ALL_RED_TIME(AR)
  ) dut (
    .clock(clock), .reset(reset), .col_request(col_request), .flash(flash),
    .row_lights(row_lights), .column_lights(column_lights),
    .remaining(remaining), .phase(phase), .tick(tick)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] ph;
    logic [6:0] rem;
    logic [2:0] row;
    logic [2:0] col;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  function automatic exp_t mk(input int ph, input int rem, input bit on);
    exp_t e;
    e.ph  = 3'(ph);
    e.rem = 7'(rem);
    case (ph)
      0:       {e.row, e.col} = {3'b001, 3'b100};
      1:       {e.row, e.col} = {3'b010, 3'b100};
      3:       {e.row, e.col} = {3'b100, 3'b001};
      4:       {e.row, e.col} = {3'b100, 3'b010};
      6:       {e.row, e.col} = on ? {3'b010, 3'b010} : {3'b000, 3'b000};
      default: {e.row, e.col} = {3'b100, 3'b100};
    endcase
    return e;
  endfunction

  task automatic push(input int ph, input int rem, input bit on = 1'b1);
    sb.push_back(mk(ph, rem, on));
  endtask

  // Waits for each of n tick pulses and compares the DUT against the queue head.
  task automatic run_ticks(input int n, input string name);
    exp_t e;
    exp_t got;
    for (int i = 0; i < n; i++) begin
      int waited = 0;
      do begin
        @(negedge clock);
        waited++;
      end while (!tick && waited < 12);
      total++;
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      if (!tick) begin
        bad++;
        $display("FAIL %s[%0d]: no tick within %0d cycles", name, i, waited);
      end else begin
        got = {phase, remaining, row_lights, column_lights};
        if (got !== e) begin
          bad++;
          $display("FAIL %s[%0d]: got ph=%0d rem=%0d row=%b col=%b, want ph=%0d rem=%0d row=%b col=%b",
                   name, i, got.ph, got.rem, got.row, got.col, e.ph, e.rem, e.row, e.col);
        end
      end
    end
  endtask

  task automatic pulse_request();
    col_request = 1'b1;
    @(negedge clock);
    col_request = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    repeat (3) @(negedge clock);
    total++;
    if ({phase, remaining, row_lights, column_lights, tick} !== {3'd5, 7'd1, 3'b100, 3'b100, 1'b0}) begin
      bad++;
      $display("FAIL reset_values: got ph=%0d rem=%0d row=%b col=%b tick=%b, want 5 1 100 100 0",
               phase, remaining, row_lights, column_lights, tick);
    end
    reset = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!tick && n < 12);
    total++;
    if (n !== DIV || tick !== 1'b1) begin
      bad++;
      $display("FAIL first_tick_latency: got %0d cycles (tick=%b), want %0d", n, tick, DIV);
    end
    total++;
    if ({phase, remaining, row_lights, column_lights} !== {3'd0, 7'd5, 3'b001, 3'b100}) begin
      bad++;
      $display("FAIL first_tick_state: got ph=%0d rem=%0d row=%b col=%b, want 0 5 001 100",
               phase, remaining, row_lights, column_lights);
    end
  endtask

  task automatic test_extension();
    for (int k = 0; k < 3; k++) begin
      for (int r = GT - 1; r >= 1; r--) push(0, r);
      push(0, GT);
    end
    run_ticks(15, "extension");
  endtask

  task automatic test_full_cycle();
    pulse_request();
    push(0, 4); push(0, 3); push(0, 2); push(0, 1);
    push(1, 2); push(1, 1); push(2, 1); push(3, 5);
    run_ticks(8, "cycle_to_col_green");
    total++;
    if (dut.col_pending !== 1'b0) begin
      bad++;
      $display("FAIL pending_cleared: got %b, want 0", dut.col_pending);
    end
    push(3, 4); push(3, 3); push(3, 2); push(3, 1);
    push(4, 2); push(4, 1); push(5, 1); push(0, 5);
    run_ticks(8, "cycle_to_row_green");
  endtask

  task automatic test_flash();
    pulse_request();
    push(0, 4); push(0, 3); push(0, 2); push(0, 1); push(1, 2);
    push(1, 1); push(2, 1); push(3, 5); push(3, 4); push(3, 3);
    run_ticks(10, "to_mid_col_green");
    flash = 1'b1;
    push(6, 0, 1'b1); push(6, 0, 1'b0); push(6, 0, 1'b1);
    run_ticks(3, "flash_on");
    flash = 1'b0;
    push(5, 1); push(0, 5);
    run_ticks(2, "flash_exit");
    // A one-cycle flash request that misses every tick must be ignored.
    flash = 1'b1;
    @(negedge clock);
    flash = 1'b0;
    push(0, 4);
    run_ticks(1, "flash_between_ticks");
  endtask

  task automatic test_request_at_entry();
    pulse_request();
    push(0, 3); push(0, 2); push(0, 1); push(1, 2); push(1, 1); push(2, 1);
    run_ticks(6, "to_clear_a");
    repeat (DIV - 1) @(negedge clock);
    col_request = 1'b1;
    push(3, 5);
    run_ticks(1, "enter_col_green");
    col_request = 1'b0;
    total++;
    if (dut.col_pending !== 1'b0) begin
      bad++;
      $display("FAIL clear_beats_set: got col_pending=%b, want 0", dut.col_pending);
    end
    push(3, 4); push(3, 3); push(3, 2); push(3, 1); push(4, 2); push(4, 1); push(5, 1);
    push(0, 5); push(0, 4); push(0, 3); push(0, 2); push(0, 1); push(0, 5);
    run_ticks(13, "extend_after_entry");
  endtask

  task automatic test_async_reset();
    int n;
    bit early;
    pulse_request();
    push(0, 4); push(0, 3); push(0, 2); push(0, 1); push(1, 2);
    run_ticks(5, "to_row_yellow");
    #2 reset = 1'b0;
    #1;
    total++;
    if ({phase, remaining, row_lights, column_lights, tick} !== {3'd5, 7'd1, 3'b100, 3'b100, 1'b0}) begin
      bad++;
      $display("FAIL async_reset_values: got ph=%0d rem=%0d row=%b col=%b tick=%b, want 5 1 100 100 0",
               phase, remaining, row_lights, column_lights, tick);
    end
    total++;
    if ({dut.div_count, dut.col_pending, dut.flash_on} !== '0) begin
      bad++;
      $display("FAIL async_reset_internal: got div=%0d pending=%b flash_on=%b, want 0 0 0",
               dut.div_count, dut.col_pending, dut.flash_on);
    end
    @(negedge clock);
    reset = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!tick && n < 12);
    total++;
    if (n !== DIV || tick !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_tick_latency: got %0d cycles (tick=%b), want %0d", n, tick, DIV);
    end
    total++;
    if ({phase, remaining, row_lights, column_lights} !== {3'd0, 7'd5, 3'b001, 3'b100}) begin
      bad++;
      $display("FAIL post_reset_state: got ph=%0d rem=%0d row=%b col=%b, want 0 5 001 100",
               phase, remaining, row_lights, column_lights);
    end
    @(negedge clock);
    early = tick;
    total++;
    if (early !== 1'b0) begin
      bad++;
      $display("FAIL tick_width: got tick=%b one cycle after pulse, want 0", early);
    end
  endtask

  initial begin
    test_reset();
    test_extension();
    test_full_cycle();
    test_flash();
    test_request_at_entry();
    test_async_reset();
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_phase_controller.md
Name: traffic_phase_controller

Overview:
- Sequences the row/column phases of the intersection.
- Derives a 1 Hz tick from the system clock and owns the per-phase countdown.
- Drives both light groups, extends row green when no column demand is pending, and supports a flashing-yellow maintenance mode.
- Its remaining-seconds output feeds the existing binary-to-BCD and seven-segment display path.

Parameters:
DIVIDER, 100000000, system clock cycles per tick (must be ≥2)
GREEN_TIME, 30, green duration in ticks (1..99)
YELLOW_TIME, 3, yellow duration in ticks (1..99)
ALL_RED_TIME, 2, all-red clearance in ticks (1..99)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low; clears all state
col_request  input  1  column vehicle/pedestrian demand (level, sampled every clock)
flash  input  1  maintenance mode request (level)
row_lights  output  3  {red,yellow,green}, one-hot or 000 during flash-off
column_lights  output  3  {red,yellow,green}
remaining  output  7  ticks left in current phase, 0..99
phase  output  3  0=ROW_GREEN 1=ROW_YELLOW 2=CLEAR_A 3=COL_GREEN 4=COL_YELLOW 5=CLEAR_B 6=FLASH
tick  output  1  one-cycle pulse per tick

Behaviour:
- All outputs registered; all state uses async active-low reset.
- Reset values: phase=CLEAR_B, remaining=ALL_RED_TIME, row_lights=column_lights=100, tick=0, divider=0, col_pending=0, flash_on=0.
- Divider: counts 0..DIVIDER-1. At terminal count it wraps to 0 and tick=1 the following cycle. First tick occurs DIVIDER cycles after reset release.
- All phase/remaining updates occur only in the cycle tick is asserted. Outputs reflect a new phase in that same cycle.
- Per tick, non-FLASH:
  - remaining>1: decrement.
  - remaining==1: advance to next phase and load its duration.
- Phase sequence: CLEAR_B→ROW_GREEN(GREEN_TIME)→ROW_YELLOW(YELLOW_TIME)→CLEAR_A(ALL_RED_TIME)→COL_GREEN(GREEN_TIME)→COL_YELLOW(YELLOW_TIME)→CLEAR_B(ALL_RED_TIME).
- Green extension: in ROW_GREEN with remaining==1 at tick and col_pending==0, stay in ROW_GREEN and reload GREEN_TIME. Column green is never extended.
- col_pending:
  - Set on any clock with col_request=1 while phase≠COL_GREEN.
  - Cleared on the tick that enters COL_GREEN; clear wins over a simultaneous set.
  - Demand arriving during COL_GREEN is ignored.
- Lights:
  - ROW_GREEN: row 001 / col 100.
  - ROW_YELLOW: 010/100.
  - CLEAR_A, CLEAR_B: 100/100.
  - COL_GREEN: 100/001.
  - COL_YELLOW: 100/010.
- Flash entry: flash=1 at a tick, from any phase including mid-countdown, enters FLASH.
  - remaining=0, flash_on toggles each tick starting at 1.
  - Both light groups = 010 when flash_on=1, 000 otherwise.
- Flash exit: flash=0 at a tick while in FLASH enters CLEAR_B with remaining=ALL_RED_TIME and flash_on=0.
- Flash changes between ticks have no effect until the next tick.
- Precedence at a tick: flash over extension over normal advance.
- No two conflicting greens in any reachable state. Every green-to-green path passes through yellow and all-red.
- Reset mid-operation: immediate return to reset values, including divider (no partial tick).

Test Plan:
1. Params DIVIDER=4, GREEN=5, YELLOW=2, ALL_RED=1; reset low 3 cycles then high -> outputs 100/100, phase=5, remaining=1; first tick at cycle 4 → phase=0, remaining=5, row_lights=001.
2. col_request pulsed 1 cycle during ROW_GREEN -> full cycle 0→1→2→3→4→5→0. Remaining reloads 5,2,1,5,2,1. Lights match the table at each tick; col_pending=0 after COL_GREEN entry.
3. col_request held 0 -> ROW_GREEN persists for ≥3 reloads (remaining 5..1,5..1,...), row_lights stays 001, column_lights stays 100.
4. flash=1 asserted mid-COL_GREEN (remaining=3) -> next tick phase=6, lights 010/010, then 000/000, alternating per tick, remaining=0. flash=0 → next tick phase=5, remaining=1, lights 100/100.
5. col_request asserted in the same cycle as the tick entering COL_GREEN -> col_pending=0 afterward; next ROW_GREEN extends.
6. reset asserted asynchronously mid-ROW_YELLOW between clock edges -> outputs reach reset values immediately without a clock edge; tick stays 0 for exactly DIVIDER cycles after release.
